// File: rtl/ycbcr_seq_mac_if.sv
// ycbcr_seq_mac_if: pixel-in / result-out handshake bundle for ycbcr_seq_mac.
//   in_valid/in_ready/r/g/b   : RGB pixel input (valid/ready)
//   out_valid/out_ready       : result handshake
//   y/cb/cr                   : Q8.16 two's complement results (offset removed)
// master = pixel source / result sink, slave = the sequencer.
interface ycbcr_seq_mac_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [31:0] cb;
    logic [31:0] cr;

    modport master (
        output in_valid, r, g, b, out_ready,
        input  in_ready, out_valid, y, cb, cr
    );

    modport slave (
        input  in_valid, r, g, b, out_ready,
        output in_ready, out_valid, y, cb, cr
    );
endinterface

// File: rtl/ycbcr_seq_mac.sv
// ycbcr_seq_mac: time-multiplexed RGB->YCbCr converter. One shared 8x16
// shift-add multiplier and one 32-bit accumulator evaluate the nine Q8.16
// products of a pixel, one per cycle, then hold Y/Cb/Cr until accepted.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : ycbcr_seq_mac_if.slave (pixel in, Y/Cb/Cr out, valid/ready)
//   busy     : FSM not in IDLE
//   pix_cnt  : completed output handshakes, wraps at 2^CNT_W
//
// Build option:
//   YCBCR_SEQ_HALF_SHIFT_EN : the two x*0x8000 terms are folded into the
//   Cb/Cr accumulator preloads as shifts, shortening MAC to 7 steps. Results
//   are bit-identical to the 9-step schedule.
module ycbcr_seq_mac #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] Y_OFFSET = 32'h0080_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    ycbcr_seq_mac_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] pix_cnt
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  step, step_nxt;
    logic [7:0]  r_q, g_q, b_q;
    logic [31:0] acc, y_q, cb_q, cr_q;

    // Per-step schedule decode
    logic [15:0] coef;
    logic [7:0]  opnd;
    logic        neg, pre, last;
    logic        wb_y, wb_cb, wb_cr;
    logic [31:0] pre_val;

    always_comb begin
        coef     = 16'h0000;
        opnd     = r_q;
        neg      = 1'b0;
        pre      = 1'b0;
        pre_val  = 32'h0;
        wb_y     = 1'b0;
        wb_cb    = 1'b0;
        wb_cr    = 1'b0;
        last     = 1'b0;
        step_nxt = step + 4'd1;
        case (step)
            4'd0: begin coef = 16'h4C8B; opnd = r_q; pre = 1'b1; pre_val = 32'h0 - Y_OFFSET; end
            4'd1: begin coef = 16'h9645; opnd = g_q; end
            4'd2: begin coef = 16'h1D2F; opnd = b_q; wb_y = 1'b1; end
            4'd3: begin
                coef = 16'h2B32; opnd = r_q; neg = 1'b1; pre = 1'b1;
`ifdef YCBCR_SEQ_HALF_SHIFT_EN
                pre_val = {9'b0, b_q, 15'b0};
`else
                pre_val = 32'h0;
`endif
            end
            4'd4: begin
                coef = 16'h54CD; opnd = g_q; neg = 1'b1;
`ifdef YCBCR_SEQ_HALF_SHIFT_EN
                wb_cb    = 1'b1;
                step_nxt = 4'd7;   // skip the two 0x8000 product steps
`endif
            end
`ifndef YCBCR_SEQ_HALF_SHIFT_EN
            4'd5: begin coef = 16'h8000; opnd = b_q; wb_cb = 1'b1; end
            4'd6: begin coef = 16'h8000; opnd = r_q; pre = 1'b1; pre_val = 32'h0; end
`endif
            4'd7: begin
                coef = 16'h6B2F; opnd = g_q; neg = 1'b1;
`ifdef YCBCR_SEQ_HALF_SHIFT_EN
                pre     = 1'b1;
                pre_val = {9'b0, r_q, 15'b0};
`endif
            end
            4'd8: begin coef = 16'h14D0; opnd = b_q; neg = 1'b1; wb_cr = 1'b1; last = 1'b1; end
            default: ;
        endcase
    end

    // Shared 8x16 shift-add multiplier; 24-bit unsigned product
    logic [23:0] prod;
    always_comb begin
        prod = 24'h0;
        for (int i = 0; i < 8; i++)
            if (opnd[i]) prod = prod + (24'(coef) << i);
    end

    logic [31:0] acc_base, acc_nxt;
    always_comb begin
        acc_base = pre ? pre_val : acc;
        acc_nxt  = neg ? acc_base - {8'h0, prod} : acc_base + {8'h0, prod};
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = MAC;
            MAC:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= 4'd0;
            r_q     <= 8'h0;
            g_q     <= 8'h0;
            b_q     <= 8'h0;
            acc     <= 32'h0;
            y_q     <= 32'h0;
            cb_q    <= 32'h0;
            cr_q    <= 32'h0;
            pix_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.in_valid) begin
                r_q  <= bus.r;
                g_q  <= bus.g;
                b_q  <= bus.b;
                step <= 4'd0;
            end
            if (state == MAC) begin
                acc  <= acc_nxt;
                step <= last ? 4'd0 : step_nxt;
                if (wb_y)  y_q  <= acc_nxt;
                if (wb_cb) cb_q <= acc_nxt;
                if (wb_cr) cr_q <= acc_nxt;
            end
            if (state == DONE && bus.out_ready)
                pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // Handshake flags decode straight from state, so in_ready can only
    // rise the cycle after the DONE->IDLE transition.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_q;
    assign bus.cb        = cb_q;
    assign bus.cr        = cr_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ycbcr_seq_mac.sv
// Directed bench for ycbcr_seq_mac: reset values, hand-computed pixels,
// latency, backpressure, async reset mid-MAC and in DONE, and a 300-pixel
// stream with CNT_W=8 against an arithmetic golden model.
module tb_ycbcr_seq_mac;
    localparam int CNT_W = 8;
`ifdef YCBCR_SEQ_HALF_SHIFT_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 9;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ycbcr_seq_mac_if bus();
    logic             busy;
    logic [CNT_W-1:0] pix_cnt;

    ycbcr_seq_mac #(.CNT_W(CNT_W), .Y_OFFSET(32'h0080_0000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .busy    (busy),
        .pix_cnt (pix_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void gold(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 output logic [31:0] y, output logic [31:0] cb, output logic [31:0] cr);
        y  = 32'(r) * 32'h4C8B + 32'(g) * 32'h9645 + 32'(b) * 32'h1D2F - 32'h0080_0000;
        cb = 32'(b) * 32'h8000 - 32'(r) * 32'h2B32 - 32'(g) * 32'h54CD;
        cr = 32'(r) * 32'h8000 - 32'(g) * 32'h6B2F - 32'(b) * 32'h14D0;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_y"},         bus.y,              32'h0);
        chk({tag, "_cb"},        bus.cb,             32'h0);
        chk({tag, "_cr"},        bus.cr,             32'h0);
        chk({tag, "_pix_cnt"},   32'(pix_cnt),       32'd0);
        chk({tag, "_busy"},      32'(busy),          32'd0);
    endtask

    // Present one pixel; returns just after the accept edge.
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        bus.r = r; bus.g = g; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pixel(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [31:0] ey, input logic [31:0] ecb, input logic [31:0] ecr);
        int lat;
        send(r, g, b);
        wait_out(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_y"},  bus.y,  ey);
        chk({tag, "_cb"}, bus.cb, ecb);
        chk({tag, "_cr"}, bus.cr, ecr);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_pix_cnt"}, 32'(pix_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [31:0] gy, gcb, gcr;
        int lat;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.r = 8'h0; bus.g = 8'h0; bus.b = 8'h0;

        #12;
        chk_reset_vals("rst_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rst_rel");

        // Hand-computed pixels
        pixel("black", 8'd0,   8'd0,   8'd0,   32'hFF80_0000, 32'h0000_0000, 32'h0000_0000);
        pixel("white", 8'd255, 8'd255, 8'd255, 32'h007E_FF01, 32'h0000_00FF, 32'h0000_00FF);
        pixel("red",   8'd255, 8'd0,   8'd0,   32'hFFCC_3E75, 32'hFFD4_F932, 32'h007F_8000);

        // Backpressure: hold for 20 cycles, results must stay put
        gold(8'd10, 8'd20, 8'd30, gy, gcb, gcr);
        send(8'd10, 8'd20, 8'd30);
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_y",  bus.y,  gy);
            chk("bp_cb", bus.cb, gcb);
            chk("bp_cr", bus.cr, gcr);
            chk("bp_pix_cnt", 32'(pix_cnt), 32'(exp_cnt));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_same_cycle", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("bp_pix_cnt_after", 32'(pix_cnt), 32'(exp_cnt));
        chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
        chk("bp_y_hold_idle", bus.y, gy);

        // Reset at MAC step 4
        send(8'd100, 8'd150, 8'd200);
        repeat (4) begin @(posedge clk); #1; end
        chk("mac_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; #1;
        chk_reset_vals("rst_mac");
        #2 rst_n = 1'b1;
        exp_cnt = 0;
        gold(8'd50, 8'd60, 8'd70, gy, gcb, gcr);
        pixel("post_rst_mac", 8'd50, 8'd60, 8'd70, gy, gcb, gcr);

        // Reset while in DONE
        send(8'd200, 8'd100, 8'd50);
        wait_out(lat);
        chk("done_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0; #1;
        chk_reset_vals("rst_done");
        #2 rst_n = 1'b1;
        exp_cnt = 0;
        gold(8'd17, 8'd201, 8'd99, gy, gcb, gcr);
        pixel("post_rst_done", 8'd17, 8'd201, 8'd99, gy, gcb, gcr);

        // Stream of 300 random pixels from a clean counter
        rst_n = 1'b0; #3 rst_n = 1'b1;
        @(posedge clk); #1;
        begin
            logic [23:0] q[$];
            logic [23:0] px;
            int acc_n = 0, done_n = 0, cyc = 0;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.r = 8'($urandom); bus.g = 8'($urandom); bus.b = 8'($urandom);
            while (done_n < 300 && cyc < 5000) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    if (q.size() == 0) chk("stream_underflow", 32'd0, 32'd1);
                    else begin
                        px = q.pop_front();
                        gold(px[23:16], px[15:8], px[7:0], gy, gcb, gcr);
                        chk("stream_y",  bus.y,  gy);
                        chk("stream_cb", bus.cb, gcb);
                        chk("stream_cr", bus.cr, gcr);
                    end
                    done_n++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back({bus.r, bus.g, bus.b});
                    acc_n++;
                end
                @(posedge clk); #1;
                cyc++;
                // Fresh random values every cycle, including during MAC
                bus.r = 8'($urandom); bus.g = 8'($urandom); bus.b = 8'($urandom);
                bus.in_valid = (acc_n < 300);
            end
            bus.in_valid = 1'b0;
            chk("stream_done", 32'(done_n), 32'd300);
            chk("stream_pix_cnt_wrap", 32'(pix_cnt), 32'd44);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
